sal_rd_buf: RTL and testbench

Read-data return buffer for the DDR2 controller, directly downstream of the scheduler and the DFI read path. It records the ID and length of every read command the scheduler issues, captures the PHY's un-throttled `dfi_rddata` beats into an in-order buffer, and replays them as AXI R beats. Each beat carries the correct `rid` and `rlast`. The block advertises a data credit so the scheduler never issues a read it cannot absorb.

---
 rtl/sal_pkg.sv | 19 +
 rtl/sal_sync_fifo.sv | 47 ++++
 rtl/sal_rd_buf.sv | 139 +++++++++++++
 tb/tb_sal_rd_buf.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_pkg.sv
// Shared types and helpers for the DDR2 controller read-return path.
// rd_cmd_t carries a fixed-width id field; blocks with a narrower AXI ID zero-extend into it.
package sal_pkg;

    localparam int SAL_ID_MAX_W = 16;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef struct packed {
        logic [SAL_ID_MAX_W-1:0] id;
        logic [3:0]              len;
    } rd_cmd_t;

    // Width of a counter able to hold every value 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sal_sync_fifo.sv
// Single-clock FIFO with an extra pointer MSB for full/empty and a head-of-queue read port.
// The caller guarantees no push when full without a same-cycle pop, and no pop when empty.
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: storage is deliberately not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/sal_rd_buf.sv
// Read-data return buffer: tracks issued read commands, buffers DFI beats, replays them as AXI R.
// Optional macro SAL_RD_BUF_BYPASS_EN presents a beat combinationally when the data FIFO is empty.
module sal_rd_buf
    import sal_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,   // must not exceed SAL_ID_MAX_W
    parameter int DEPTH     = 32,
    parameter int CMD_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_cmd_valid_i,
    output logic                    rd_cmd_ready_o,
    input  logic [ID_W-1:0]         rd_cmd_id_i,
    input  logic [3:0]              rd_cmd_len_i,
    output logic [$clog2(DEPTH):0]  rd_credit_o,
    input  logic                    dfi_rddata_valid_i,
    input  logic [DATA_W-1:0]       dfi_rddata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [ID_W-1:0]         rid_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    orphan_o
);

    localparam int CW     = credit_w(DEPTH);
    localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]        state, state_nxt;
    logic [CW-1:0]     reserved;
    logic [CW-1:0]     expected;
    logic [3:0]        beat_cnt;
    logic              orphan_q;

    logic [CW-1:0]     len_plus1;
    logic              cmd_push, cmd_pop, cmd_full, cmd_empty_unused;
    logic [CMD_CW-1:0] cmd_count;
    rd_cmd_t           cmd_wr, cmd_head;

    logic              beat_ok, bypass, streaming, r_hs;
    logic              data_push, data_pop, data_empty;
    logic              data_full_unused;
    logic [CW-1:0]     data_count_unused;
    logic [DATA_W-1:0] data_head;

    assign len_plus1      = CW'(rd_cmd_len_i) + CW'(1);
    assign rd_credit_o    = CW'(DEPTH) - reserved;
    assign rd_cmd_ready_o = !cmd_full && (rd_credit_o >= len_plus1);
    assign cmd_push       = rd_cmd_valid_i && rd_cmd_ready_o;
    assign cmd_wr         = '{id: SAL_ID_MAX_W'(rd_cmd_id_i), len: rd_cmd_len_i};

    sal_sync_fifo #(.WIDTH($bits(rd_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cmd_push),
        .wr_data (cmd_wr),
        .rd_en   (cmd_pop),
        .rd_data (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty_unused),
        .count   (cmd_count)
    );

    // Beats arriving with nothing outstanding are dropped and flagged.
    assign beat_ok   = dfi_rddata_valid_i && (expected != '0);
    assign streaming = (state == ST_STREAM);

`ifdef SAL_RD_BUF_BYPASS_EN
    assign bypass = streaming && data_empty && beat_ok;
`else
    assign bypass = 1'b0;
`endif

    assign rvalid_o = streaming && (!data_empty || bypass);
    assign rdata_o  = !rvalid_o ? '0 : (data_empty ? dfi_rddata_i : data_head);
    assign rid_o    = streaming ? ID_W'(cmd_head.id) : '0;
    assign rlast_o  = streaming && (beat_cnt == cmd_head.len);
    assign rresp_o  = RRESP_OKAY;
    assign orphan_o = orphan_q;

    assign r_hs      = rvalid_o && rready_i;
    assign cmd_pop   = r_hs && rlast_o;
    assign data_pop  = r_hs && !data_empty;
    assign data_push = beat_ok && !(bypass && rready_i);

    sal_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (data_push),
        .wr_data (dfi_rddata_i),
        .rd_en   (data_pop),
        .rd_data (data_head),
        .full    (data_full_unused),
        .empty   (data_empty),
        .count   (data_count_unused)
    );

    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_push) state_nxt = ST_STREAM;
            end
            default: begin
                if (cmd_pop && (cmd_count == CMD_CW'(1)) && !cmd_push) state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            reserved <= '0;
            expected <= '0;
            beat_cnt <= '0;
            orphan_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            reserved <= reserved + (cmd_push ? len_plus1 : '0) - (r_hs ? CW'(1) : '0);
            expected <= expected + (cmd_push ? len_plus1 : '0) - (beat_ok ? CW'(1) : '0);
            if (cmd_pop) begin
                beat_cnt <= '0;
            end else if (r_hs) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
            if (dfi_rddata_valid_i && (expected == '0)) begin
                orphan_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sal_rd_buf.sv
// Randomized bench for sal_rd_buf, checked every cycle against a queue-based reference model.
// The model also covers the SAL_RD_BUF_BYPASS_EN build when that macro is defined.
module tb_sal_rd_buf;

    localparam int DATA_W    = 128;
    localparam int ID_W      = 4;
    localparam int DEPTH     = 32;
    localparam int CMD_DEPTH = 8;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ID_W-1:0]   rd_cmd_id;
    logic [3:0]        rd_cmd_len;
    logic [CW-1:0]     rd_credit;
    logic              dfi_valid;
    logic [DATA_W-1:0] dfi_data;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              orphan;

    sal_rd_buf #(.DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .CMD_DEPTH(CMD_DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rd_cmd_valid_i     (rd_cmd_valid),
        .rd_cmd_ready_o     (rd_cmd_ready),
        .rd_cmd_id_i        (rd_cmd_id),
        .rd_cmd_len_i       (rd_cmd_len),
        .rd_credit_o        (rd_credit),
        .dfi_rddata_valid_i (dfi_valid),
        .dfi_rddata_i       (dfi_data),
        .rvalid_o           (rvalid),
        .rready_i           (rready),
        .rid_o              (rid),
        .rdata_o            (rdata),
        .rresp_o            (rresp),
        .rlast_o            (rlast),
        .orphan_o           (orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: outstanding bursts, buffered beats, and plain integer bookkeeping.
    typedef struct { int id; int len; } mcmd_t;
    mcmd_t             m_cmd[$];
    logic [DATA_W-1:0] m_data[$];
    int                m_beat, m_res, m_exp;
    bit                m_orphan;

    bit                e_ready, e_rvalid, e_rlast, e_byp;
    int                e_credit;
    logic [ID_W-1:0]   e_rid;
    logic [DATA_W-1:0] e_rdata;

    task automatic model_reset();
        m_cmd.delete();
        m_data.delete();
        m_beat = 0; m_res = 0; m_exp = 0; m_orphan = 0;
    endtask

    task automatic compute_exp();
        bit stream;
        e_credit = DEPTH - m_res;
        e_ready  = (m_cmd.size() < CMD_DEPTH) && (e_credit >= int'(rd_cmd_len) + 1);
        stream   = (m_cmd.size() > 0);
        e_byp    = 0;
`ifdef SAL_RD_BUF_BYPASS_EN
        e_byp    = stream && (m_data.size() == 0) && dfi_valid && (m_exp > 0);
`endif
        e_rvalid = stream && ((m_data.size() > 0) || e_byp);
        e_rdata  = '0;
        if (e_rvalid) e_rdata = (m_data.size() > 0) ? m_data[0] : dfi_data;
        e_rid    = '0;
        e_rlast  = 0;
        if (stream) begin
            e_rid   = m_cmd[0].id[ID_W-1:0];
            e_rlast = (m_beat == m_cmd[0].len);
        end
    endtask

    task automatic check_outputs();
        compute_exp();
        check("rd_cmd_ready", rd_cmd_ready, e_ready);
        check("rd_credit",    rd_credit,    e_credit);
        check("rvalid",       rvalid,       e_rvalid);
        check("rid",          rid,          e_rid);
        check("rdata",        rdata,        e_rdata);
        check("rlast",        rlast,        e_rlast);
        check("rresp",        rresp,        2'b00);
        check("orphan",       orphan,       m_orphan);
    endtask

    task automatic update_model();
        bit hs, push;
        hs   = e_rvalid && rready;
        push = rd_cmd_valid && e_ready;
        if (hs && (m_data.size() > 0)) void'(m_data.pop_front());
        if (dfi_valid) begin
            if (m_exp == 0) m_orphan = 1;
            else begin
                m_exp--;
                if (!(e_byp && rready)) m_data.push_back(dfi_data);
            end
        end
        if (hs) begin
            m_res--;
            if (e_rlast) begin
                void'(m_cmd.pop_front());
                m_beat = 0;
            end else m_beat++;
        end
        if (push) begin
            m_cmd.push_back('{id: int'(rd_cmd_id), len: int'(rd_cmd_len)});
            m_res += int'(rd_cmd_len) + 1;
            m_exp += int'(rd_cmd_len) + 1;
        end
    endtask

    task automatic step(input bit cv, input int id, input int len, input bit dv,
                        input logic [DATA_W-1:0] d, input bit rr);
        @(negedge clk);
        rd_cmd_valid = cv;
        rd_cmd_id    = id[ID_W-1:0];
        rd_cmd_len   = len[3:0];
        dfi_valid    = dv;
        dfi_data     = d;
        rready       = rr;
        #1;
        check_outputs();
        @(posedge clk);
        update_model();
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain();
        for (int i = 0; i < 200 && (m_cmd.size() > 0 || m_exp > 0); i++)
            step(0, 0, 0, m_exp > 0, rnd_data(), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, rvalid,       1'b0);
        check({tag, "_rlast"},  rlast,        1'b0);
        check({tag, "_rid"},    rid,          '0);
        check({tag, "_rdata"},  rdata,        '0);
        check({tag, "_rresp"},  rresp,        2'b00);
        check({tag, "_orphan"}, orphan,       1'b0);
        check({tag, "_ready"},  rd_cmd_ready, 1'b1);
        check({tag, "_credit"}, rd_credit,    DEPTH);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rd_cmd_valid = 0; rd_cmd_id = '0; rd_cmd_len = '0;
        dfi_valid = 0; dfi_data = '0; rready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single burst: id 3, four beats, credit 32 -> 28 -> 32.
        step(1, 3, 3, 0, '0, 1);
        #1 check("t1_credit_accept", rd_credit, 28);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 128'hA0 + 128'(i), 1);
        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 1);
        #1 check("t1_credit_back", rd_credit, DEPTH);

        // Back-to-back 16-beat bursts exhaust credit; a third command must stall.
        step(1, 1, 15, 0, '0, 0);
        step(1, 2, 15, 0, '0, 0);
        #1 check("t2_credit_zero", rd_credit, 0);
        step(1, 7, 0, 0, '0, 0);
        #1 check("t2_ready_len0", rd_cmd_ready, 1'b0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, m_exp > 0, rnd_data(), 1);

        // Backpressure for 10 cycles mid-burst.
        step(1, 4, 9, 0, '0, 1);
        for (int i = 0; i < 30; i++) step(0, 0, 0, m_exp > 0, rnd_data(), !(i >= 3 && i < 13));
        drain();

        // Accept id 5 len 7 in the same cycle as a handshake, with reserved = 4.
        step(1, 0, 3, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, rnd_data(), 0);
        step(1, 5, 7, 0, '0, 1);
        #1 check("t5_credit_21", rd_credit, 21);
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 15),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3),
                 (m_exp > 0) && ($urandom_range(0, 3) != 0), rnd_data(),
                 $urandom_range(0, 3) != 0);
        drain();

        // Orphan beat with nothing outstanding.
        step(0, 0, 0, 1, rnd_data(), 1);
        #1;
        check("t4_orphan", orphan, 1'b1);
        check("t4_rvalid", rvalid, 1'b0);
        check("t4_credit", rd_credit, DEPTH);
        step(0, 0, 0, 0, '0, 1);

        // Reset asserted mid-burst after two of eight beats.
        step(1, 6, 7, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rnd_data(), 1);
        @(negedge clk);
        rd_cmd_valid = 0; rd_cmd_len = '0; dfi_valid = 0; rready = 1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh burst after reset; with bypass enabled its first beat returns in the same cycle.
        step(1, 11, 2, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rnd_data(), 1);
        drain();
        step(0, 0, 0, 0, '0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
